// File: rtl/macro_cell_evaluator_pkg.sv
// Shared encodings for the macro/micro board evaluators: cell and outcome codes,
// FSM states and the tic-tac-toe win-line table (cell indices 0..8, row-major).
package macro_cell_evaluator_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  localparam logic [1:0] RES_ANDAMENTO = 2'b00;
  localparam logic [1:0] RES_P1        = 2'b01;
  localparam logic [1:0] RES_P2        = 2'b10;
  localparam logic [1:0] RES_EMPATE    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_EVAL  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  // Cell k of the board (1..9) lives at index k-1.
  typedef logic [8:0][1:0] cells_t;

  localparam int unsigned N_LINES = 8;

  localparam logic [3:0] WIN_LINES [N_LINES][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

endpackage

// File: rtl/macro_cell_evaluator_tic_tac_toe_check.sv
// Combinational 3x3 board judge: P1 line beats P2 line, then full board is a draw.
// Code 11 never matches a player, so it behaves as an empty cell.
module tic_tac_toe_check
  import macro_cell_evaluator_pkg::*;
(
  input  cells_t     cells,
  output logic [1:0] outcome
);

  logic w_p1_line;
  logic w_p2_line;
  logic w_full;

  always_comb begin
    w_p1_line = 1'b0;
    w_p2_line = 1'b0;
    w_full    = 1'b1;
    for (int l = 0; l < N_LINES; l++) begin
      if (cells[WIN_LINES[l][0]] == CELL_P1 && cells[WIN_LINES[l][1]] == CELL_P1 &&
          cells[WIN_LINES[l][2]] == CELL_P1)
        w_p1_line = 1'b1;
      if (cells[WIN_LINES[l][0]] == CELL_P2 && cells[WIN_LINES[l][1]] == CELL_P2 &&
          cells[WIN_LINES[l][2]] == CELL_P2)
        w_p2_line = 1'b1;
    end
    for (int c = 0; c < 9; c++) begin
      if (cells[c] != CELL_P1 && cells[c] != CELL_P2)
        w_full = 1'b0;
    end

    if (w_p1_line)      outcome = RES_P1;
    else if (w_p2_line) outcome = RES_P2;
    else if (w_full)    outcome = RES_EMPATE;
    else                outcome = RES_ANDAMENTO;
  end

endmodule

// File: rtl/macro_cell_evaluator.sv
// Reads the 9 cells of one micro board, judges it and writes the outcome into the
// macro-board state RAM. Start-to-done latency is 12 cycles.
module macro_cell_evaluator
  import macro_cell_evaluator_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] macro_addr,
  output logic [7:0] rd_addr,
  input  logic [1:0] rd_data,
  output logic       board_we,
  output logic [3:0] board_addr,
  output logic [1:0] board_data,
  output logic       busy,
  output logic       done,
  output logic [1:0] result
);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_macro;
  logic [3:0] r_idx;
  cells_t     r_cells;
  logic [7:0] r_rd_addr;
  logic       r_board_we;
  logic [3:0] r_board_addr;
  logic [1:0] r_board_data;
  logic       r_busy;
  logic       r_done;
  logic [1:0] r_result;

  logic       w_accept;
  logic       w_last_rd;
  logic [1:0] w_outcome;

  assign w_accept  = (r_state == ST_IDLE) && start &&
                     (macro_addr >= 4'd1) && (macro_addr <= 4'd9);
  assign w_last_rd = (r_idx == 4'd9);

  tic_tac_toe_check u_check (
    .cells   (r_cells),
    .outcome (w_outcome)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_READ;
      ST_READ:  if (w_last_rd) w_next = ST_DRAIN;
      ST_DRAIN: w_next = ST_EVAL;
      ST_EVAL:  w_next = ST_WRITE;
      ST_WRITE: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // RAM data lags the address by one cycle, so cell k-1 arrives while address k is out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_macro      <= 4'd0;
      r_idx        <= 4'd0;
      r_cells      <= '0;
      r_rd_addr    <= 8'd0;
      r_board_we   <= 1'b0;
      r_board_addr <= 4'd0;
      r_board_data <= 2'b00;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_result     <= RES_ANDAMENTO;
    end else begin
      r_board_we <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_macro   <= macro_addr;
            r_idx     <= 4'd1;
            r_rd_addr <= {macro_addr, 4'd1};
            r_busy    <= 1'b1;
            r_result  <= RES_ANDAMENTO;
          end
        end
        ST_READ: begin
          if (r_idx != 4'd1)
            r_cells[r_idx - 4'd2] <= rd_data;
          if (w_last_rd) begin
            r_rd_addr <= 8'd0;
          end else begin
            r_idx     <= r_idx + 4'd1;
            r_rd_addr <= {r_macro, r_idx + 4'd1};
          end
        end
        ST_DRAIN: r_cells[8] <= rd_data;
        ST_EVAL: begin
          r_result <= w_outcome;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          if (w_outcome != RES_ANDAMENTO) begin
            r_board_we   <= 1'b1;
            r_board_addr <= r_macro;
            r_board_data <= w_outcome;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_addr    = r_rd_addr;
  assign board_we   = r_board_we;
  assign board_addr = r_board_addr;
  assign board_data = r_board_data;
  assign busy       = r_busy;
  assign done       = r_done;
  assign result     = r_result;

endmodule

// File: tb/tb_macro_cell_evaluator.sv
// Scoreboard bench for macro_cell_evaluator: driver queues expected evaluations,
// a negedge monitor checks every output cycle by cycle against a grid-based model.
module tb_macro_cell_evaluator;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] macro_addr;
  logic [7:0] rd_addr;
  logic [1:0] rd_data;
  logic       board_we;
  logic [3:0] board_addr;
  logic [1:0] board_data;
  logic       busy;
  logic       done;
  logic [1:0] result;

  macro_cell_evaluator dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .macro_addr (macro_addr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .board_we   (board_we),
    .board_addr (board_addr),
    .board_data (board_data),
    .busy       (busy),
    .done       (done),
    .result     (result)
  );

  typedef struct {
    int         t0;
    logic [3:0] addr;
    logic [1:0] res;
  } txn_t;

  txn_t       sbq[$];
  logic [1:0] mem [256];
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  bit         have = 0;
  int         last_t0 = 0;
  logic [1:0] exp_res = 0;
  logic [3:0] exp_ba = 0;
  logic [1:0] exp_bd = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rd_data <= mem[rd_addr];

  initial begin
    #300000;
    $display("FAIL watchdog: bench did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Reference: lay the cells out as a 3x3 grid and scan rows, columns and diagonals.
  function automatic logic [1:0] ref_eval(input logic [8:0][1:0] c);
    int g[3][3];
    bit win1 = 0;
    bit win2 = 0;
    bit full = 1;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++) begin
        g[r][k] = (c[3*r+k] == 2'b01) ? 1 : (c[3*r+k] == 2'b10) ? 2 : 0;
        if (g[r][k] == 0) full = 0;
      end
    for (int p = 1; p <= 2; p++) begin
      bit w = 0;
      for (int i = 0; i < 3; i++) begin
        if (g[i][0] == p && g[i][1] == p && g[i][2] == p) w = 1;
        if (g[0][i] == p && g[1][i] == p && g[2][i] == p) w = 1;
      end
      if (g[0][0] == p && g[1][1] == p && g[2][2] == p) w = 1;
      if (g[0][2] == p && g[1][1] == p && g[2][0] == p) w = 1;
      if (p == 1) win1 = w; else win2 = w;
    end
    if (win1) return 2'b01;
    if (win2) return 2'b10;
    return full ? 2'b11 : 2'b00;
  endfunction

  function automatic logic [8:0][1:0] get_board(input logic [3:0] a);
    logic [8:0][1:0] b;
    for (int k = 1; k <= 9; k++) begin
      logic [3:0] kk;
      kk = k[3:0];
      b[k-1] = mem[{a, kk}];
    end
    return b;
  endfunction

  task automatic load_board(input logic [3:0] a, input logic [8:0][1:0] b);
    for (int k = 1; k <= 9; k++) begin
      logic [3:0] kk;
      kk = k[3:0];
      mem[{a, kk}] = b[k-1];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] a);
    txn_t t;
    start = 1'b1;
    macro_addr = a;
    if (a >= 1 && a <= 9 && !(have && cyc <= last_t0 + 12)) begin
      t.t0 = cyc;
      t.addr = a;
      t.res = ref_eval(get_board(a));
      sbq.push_back(t);
      have = 1;
      last_t0 = cyc;
    end
    tick();
    start = 1'b0;
    macro_addr = 4'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && have && cyc <= last_t0 + 12; i++) tick();
    tick();
  endtask

  // Monitor: judges every cycle from the head of the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      sbq.delete();
      exp_res = 0;
      exp_ba = 0;
      exp_bd = 0;
    end else begin
      int d;
      logic [7:0] e_rd;
      logic [3:0] dd;
      d = (sbq.size() != 0) ? cyc - sbq[0].t0 : -1;
      dd = d[3:0];
      e_rd = (d >= 1 && d <= 9) ? {sbq[0].addr, dd} : 8'h00;
      if (d >= 1 && d <= 11) exp_res = 2'b00;
      if (d == 12) begin
        exp_res = sbq[0].res;
        if (sbq[0].res != 2'b00) begin
          exp_ba = sbq[0].addr;
          exp_bd = sbq[0].res;
        end
      end
      chk("busy", {7'd0, busy}, {7'd0, (d >= 1 && d <= 11)});
      chk("done", {7'd0, done}, {7'd0, (d == 12)});
      chk("board_we", {7'd0, board_we}, {7'd0, (d == 12 && exp_res != 2'b00)});
      chk("rd_addr", rd_addr, e_rd);
      chk("result", {6'd0, result}, {6'd0, exp_res});
      chk("board_addr", {4'd0, board_addr}, {4'd0, exp_ba});
      chk("board_data", {6'd0, board_data}, {6'd0, exp_bd});
      if (d == 12) void'(sbq.pop_front());
      if (d > 12) begin
        chk("done_timeout", 8'd1, 8'd0);
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    logic [8:0][1:0] b;
    reset = 1'b1;
    start = 1'b0;
    macro_addr = 4'd0;
    for (int i = 0; i < 256; i++) mem[i] = 2'($urandom_range(0, 3));
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset during READ aborts, then a fresh start completes.
    b = '0; b[0] = 2'b01; b[4] = 2'b01; b[8] = 2'b01;
    load_board(4'd4, b);
    issue(4'd4);
    repeat (4) tick();
    reset = 1'b1;
    have = 0;
    tick();
    reset = 1'b0;
    tick();
    issue(4'd4);
    wait_idle();

    // Board 3: top row P1.
    b = '0; b[0] = 2'b01; b[1] = 2'b01; b[2] = 2'b01;
    load_board(4'd3, b);
    issue(4'd3);
    wait_idle();

    // Board 7: anti-diagonal P2, result must hold afterwards.
    b = '0; b[2] = 2'b10; b[4] = 2'b10; b[6] = 2'b10;
    load_board(4'd7, b);
    issue(4'd7);
    wait_idle();
    repeat (5) tick();

    // Board 1: full draw, then same with cell 9 empty.
    b = {2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b01};
    load_board(4'd1, b);
    issue(4'd1);
    wait_idle();
    b[8] = 2'b00;
    load_board(4'd1, b);
    issue(4'd1);
    wait_idle();

    // Illegal board with both players winning: P1 priority.
    b = {2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
    load_board(4'd8, b);
    issue(4'd8);
    wait_idle();

    // Invalid addresses, and a start while busy.
    issue(4'd0);
    issue(4'd10);
    issue(4'd15);
    repeat (3) tick();
    issue(4'd5);
    repeat (3) tick();
    issue(4'd6);
    wait_idle();

    // Back-to-back: second start in the cycle after done.
    b = '0; b[1] = 2'b10; b[4] = 2'b10; b[7] = 2'b10;
    load_board(4'd2, b);
    b = '0; b[3] = 2'b01; b[4] = 2'b01; b[5] = 2'b01;
    load_board(4'd5, b);
    issue(4'd2);
    while (cyc < last_t0 + 13) tick();
    issue(4'd5);
    wait_idle();

    // Random boards, addresses and overlapping starts.
    for (int it = 0; it < 40; it++) begin
      logic [3:0] a;
      wait_idle();
      a = 4'($urandom_range(1, 9));
      for (int k = 0; k < 9; k++) b[k] = 2'($urandom_range(0, 3));
      load_board(a, b);
      issue(a);
      repeat ($urandom_range(0, 14)) tick();
      issue(4'($urandom_range(0, 15)));
    end
    wait_idle();
    repeat (3) tick();
    chk("scoreboard_empty", 8'(sbq.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
